// File: rtl/mushroom_pkg.sv
// Shared types and default geometry for the power-up mushroom and its reusable overlap helper.
package mushroom_pkg;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned SIZE_DEF     = 16;
    localparam int unsigned SCREEN_W_DEF = 640;
    localparam int unsigned SCREEN_H_DEF = 480;

    typedef enum logic [2:0] {IDLE, EMERGE, WALK, FALL, DONE} mush_state_t;

    typedef enum logic {LEFT, RIGHT} dir_t;

    // Axis-aligned box: top-left corner plus extent, all in screen pixels.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } box_t;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap; shared by mushroom, goomba and coin movers.
module aabb_overlap
    import mushroom_pkg::*;
(
    input  box_t a,
    input  box_t b,
    output logic overlap_c
);

    localparam int unsigned EXT_W = COORD_W + 1;

    // Widen before adding so far-right or far-bottom boxes cannot wrap.
    always_comb begin
        overlap_c = (EXT_W'(a.x) < EXT_W'(b.x) + EXT_W'(b.w)) &&
                    (EXT_W'(b.x) < EXT_W'(a.x) + EXT_W'(a.w)) &&
                    (EXT_W'(a.y) < EXT_W'(b.y) + EXT_W'(b.h)) &&
                    (EXT_W'(b.y) < EXT_W'(a.y) + EXT_W'(a.h));
    end

endmodule

// File: rtl/mushroom_motion.sv
// Power-up mushroom mover: rises from the struck block, walks, falls and reports Mario pickup.
module mushroom_motion
    import mushroom_pkg::*;
#(
    parameter int unsigned SIZE       = SIZE_DEF,
    parameter int unsigned WALK_SPEED = 1,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned MAX_FALL   = 4,
    parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H   = SCREEN_H_DEF,
    parameter int unsigned MARIO_W    = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               spawn,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic [COORD_W-1:0] mario_x,
    input  logic [COORD_W-1:0] mario_y,
    input  logic [5:0]         mario_h,
    input  logic               ground_below,
    output logic [COORD_W-1:0] mush_x,
    output logic [COORD_W-1:0] mush_y,
    output logic               mush_active,
    output logic               collision
);

    localparam int unsigned EXT_W = COORD_W + 1;

    mush_state_t        state, state_nx;
    dir_t               dir, dir_nx;
    logic [COORD_W-1:0] x_nx, y_nx;
    logic [COORD_W-1:0] vy, vy_nx;
    logic [COORD_W-1:0] cnt, cnt_nx;
    logic               active_nx, coll_nx;

    logic               in_play_c, overlap_c;
    logic [EXT_W-1:0]   x_right_c, vy_sum_c, y_fall_c;
    logic [COORD_W-1:0] vy_inc_c;
    box_t               mush_box_c, mario_box_c;

    assign in_play_c   = (state == EMERGE) || (state == WALK) || (state == FALL);
    assign mush_box_c  = '{x: mush_x, y: mush_y, w: COORD_W'(SIZE), h: COORD_W'(SIZE)};
    assign mario_box_c = '{x: mario_x, y: mario_y, w: COORD_W'(MARIO_W), h: COORD_W'(mario_h)};

    aabb_overlap u_overlap (
        .a         (mario_box_c),
        .b         (mush_box_c),
        .overlap_c (overlap_c)
    );

    // Motion arithmetic in widened form so wall and floor compares cannot wrap.
    always_comb begin
        x_right_c = EXT_W'(mush_x) + EXT_W'(WALK_SPEED) + EXT_W'(SIZE);
        vy_sum_c  = EXT_W'(vy) + EXT_W'(GRAVITY);
        vy_inc_c  = (vy_sum_c > EXT_W'(MAX_FALL)) ? COORD_W'(MAX_FALL) : vy_sum_c[COORD_W-1:0];
        y_fall_c  = EXT_W'(mush_y) + EXT_W'(vy_inc_c);
    end

    // Next-state and datapath; a pickup takes priority over any frame step.
    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        x_nx     = mush_x;
        y_nx     = mush_y;
        vy_nx    = vy;
        cnt_nx   = cnt;
        coll_nx  = 1'b0;

        if (in_play_c && overlap_c) begin
            state_nx = DONE;
            coll_nx  = 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (spawn) begin
                        x_nx     = spawn_x;
                        y_nx     = spawn_y;
                        cnt_nx   = COORD_W'(SIZE);
                        dir_nx   = RIGHT;
                        vy_nx    = '0;
                        state_nx = EMERGE;
                    end
                end
                EMERGE: begin
                    if (frame_tick) begin
                        y_nx   = (mush_y == '0) ? '0 : mush_y - COORD_W'(1);
                        cnt_nx = cnt - COORD_W'(1);
                        if (cnt <= COORD_W'(1)) begin
                            state_nx = WALK;
                        end
                    end
                end
                WALK: begin
                    if (frame_tick) begin
                        if (!ground_below) begin
                            state_nx = FALL;
                        end else if (dir == RIGHT) begin
                            if (x_right_c >= EXT_W'(SCREEN_W)) begin
                                x_nx   = COORD_W'(SCREEN_W - SIZE);
                                dir_nx = LEFT;
                            end else begin
                                x_nx = mush_x + COORD_W'(WALK_SPEED);
                            end
                        end else begin
                            if (EXT_W'(mush_x) < EXT_W'(WALK_SPEED)) begin
                                x_nx   = '0;
                                dir_nx = RIGHT;
                            end else begin
                                x_nx = mush_x - COORD_W'(WALK_SPEED);
                            end
                        end
                    end
                end
                FALL: begin
                    if (frame_tick) begin
                        if (ground_below) begin
                            vy_nx    = '0;
                            state_nx = WALK;
                        end else begin
                            vy_nx = vy_inc_c;
                            y_nx  = y_fall_c[COORD_W-1:0];
                            if (y_fall_c >= EXT_W'(SCREEN_H)) begin
                                state_nx = DONE;
                            end
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        active_nx = (state_nx == EMERGE) || (state_nx == WALK) || (state_nx == FALL);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            dir         <= RIGHT;
            mush_x      <= '0;
            mush_y      <= '0;
            vy          <= '0;
            cnt         <= '0;
            mush_active <= 1'b0;
            collision   <= 1'b0;
        end else begin
            state       <= state_nx;
            dir         <= dir_nx;
            mush_x      <= x_nx;
            mush_y      <= y_nx;
            vy          <= vy_nx;
            cnt         <= cnt_nx;
            mush_active <= active_nx;
            collision   <= coll_nx;
        end
    end

endmodule

// File: tb/tb_mushroom_motion.sv
// Self-checking bench for mushroom_motion: directed scenarios plus randomized play against a behavioural model.
module tb_mushroom_motion;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       spawn = 1'b0;
    logic       ground_below = 1'b1;
    logic [9:0] spawn_x = '0, spawn_y = '0, mario_x = '0, mario_y = '0;
    logic [5:0] mario_h = 6'd16;
    logic [9:0] mush_x, mush_y;
    logic       mush_active, collision;

    int checks = 0;
    int errors = 0;

    localparam int MD_IDLE = 0, MD_RISE = 1, MD_WALK = 2, MD_FALL = 3, MD_GONE = 4;
    int m_mode, m_x, m_y, m_vy, m_rise, m_coll;
    bit m_right;

    mushroom_motion dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .spawn        (spawn),
        .spawn_x      (spawn_x),
        .spawn_y      (spawn_y),
        .mario_x      (mario_x),
        .mario_y      (mario_y),
        .mario_h      (mario_h),
        .ground_below (ground_below),
        .mush_x       (mush_x),
        .mush_y       (mush_y),
        .mush_active  (mush_active),
        .collision    (collision)
    );

    always #5 Clk = ~Clk;

    function automatic void model_reset();
        m_mode = MD_IDLE; m_x = 0; m_y = 0; m_vy = 0; m_rise = 0; m_coll = 0; m_right = 1;
    endfunction

    function automatic bit model_in_play();
        return (m_mode == MD_RISE) || (m_mode == MD_WALK) || (m_mode == MD_FALL);
    endfunction

    function automatic bit model_touch();
        int mx = int'(mario_x);
        int my = int'(mario_y);
        return (mx < m_x + 16) && (m_x < mx + 16) && (my < m_y + 16) && (m_y < my + int'(mario_h));
    endfunction

    // One clock of the game rules, in plain integer arithmetic.
    function automatic void model_step();
        if (model_in_play() && model_touch()) begin
            m_mode = MD_GONE;
            m_coll = 1;
            return;
        end
        m_coll = 0;
        if (m_mode == MD_IDLE || m_mode == MD_GONE) begin
            if (spawn) begin
                m_x = int'(spawn_x); m_y = int'(spawn_y); m_rise = 16; m_right = 1; m_vy = 0;
                m_mode = MD_RISE;
            end
        end else if (frame_tick) begin
            if (m_mode == MD_RISE) begin
                if (m_y > 0) m_y--;
                m_rise--;
                if (m_rise == 0) m_mode = MD_WALK;
            end else if (m_mode == MD_WALK) begin
                if (!ground_below) m_mode = MD_FALL;
                else if (m_right) begin
                    if (m_x + 17 >= 640) begin m_x = 624; m_right = 0; end
                    else m_x++;
                end else begin
                    if (m_x < 1) begin m_x = 0; m_right = 1; end
                    else m_x--;
                end
            end else begin
                if (ground_below) begin
                    m_vy = 0; m_mode = MD_WALK;
                end else begin
                    m_vy = (m_vy + 1 > 4) ? 4 : m_vy + 1;
                    m_y = m_y + m_vy;
                    if (m_y >= 480) m_mode = MD_GONE;
                end
            end
        end
    endfunction

    task automatic cyc(input bit tick, input bit sp);
        frame_tick = tick;
        spawn = sp;
        @(posedge Clk);
        model_step();
        #1;
        frame_tick = 1'b0;
        spawn = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        #3;
        Reset_n = 1'b1;
    endtask

    task automatic mario_far();
        mario_x = 10'd600; mario_y = 10'd0; mario_h = 6'd16;
    endtask

    task automatic spawn_and_rise(input int sx, input int sy);
        spawn_x = 10'(sx); spawn_y = 10'(sy);
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        model_reset();
        #2;
        checks++; if (mush_x !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", mush_x); end
        checks++; if (mush_y !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", mush_y); end
        checks++; if (mush_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", mush_active); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %b want 0", collision); end
        Reset_n = 1'b1;
    endtask

    task automatic test_emerge();
        mario_far();
        ground_below = 1'b1;
        spawn_x = 10'd100; spawn_y = 10'd200;
        cyc(1'b0, 1'b1);
        checks++; if (mush_active !== 1'b1 || mush_x !== 10'd100 || mush_y !== 10'd200) begin
            errors++; $display("FAIL emerge_spawn: got active=%b x=%0d y=%0d want 1 100 200", mush_active, mush_x, mush_y);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0);
            checks++; if (mush_y !== 10'(199 - i) || mush_x !== 10'd100) begin
                errors++; $display("FAIL emerge_step%0d: got x=%0d y=%0d want 100 %0d", i, mush_x, mush_y, 199 - i);
            end
        end
        cyc(1'b1, 1'b0);
        checks++; if (mush_x !== 10'd101 || mush_y !== 10'd184) begin
            errors++; $display("FAIL emerge_first_walk: got x=%0d y=%0d want 101 184", mush_x, mush_y);
        end
    endtask

    task automatic test_right_wall();
        do_reset();
        mario_far();
        ground_below = 1'b1;
        spawn_and_rise(607, 200);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0);
        checks++; if (mush_x !== 10'd623) begin errors++; $display("FAIL wall_approach: got %0d want 623", mush_x); end
        cyc(1'b1, 1'b0);
        checks++; if (mush_x !== 10'd624) begin errors++; $display("FAIL wall_clamp: got %0d want 624", mush_x); end
        cyc(1'b1, 1'b0);
        checks++; if (mush_x !== 10'd623) begin errors++; $display("FAIL wall_turn: got %0d want 623", mush_x); end
    endtask

    task automatic test_fall();
        int exp_y[5] = '{301, 303, 306, 310, 314};
        do_reset();
        mario_far();
        ground_below = 1'b1;
        spawn_and_rise(50, 316);
        ground_below = 1'b0;
        cyc(1'b1, 1'b0);
        checks++; if (mush_y !== 10'd300 || mush_x !== 10'd50) begin
            errors++; $display("FAIL fall_enter: got x=%0d y=%0d want 50 300", mush_x, mush_y);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0);
            checks++; if (mush_y !== 10'(exp_y[i]) || mush_x !== 10'd50) begin
                errors++; $display("FAIL fall_step%0d: got x=%0d y=%0d want 50 %0d", i, mush_x, mush_y, exp_y[i]);
            end
        end
        ground_below = 1'b1;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        checks++; if (mush_x !== 10'd51 || mush_y !== 10'd314) begin
            errors++; $display("FAIL fall_land: got x=%0d y=%0d want 51 314", mush_x, mush_y);
        end
        ground_below = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        checks++; if (mush_y !== 10'd315) begin errors++; $display("FAIL fall_vy_cleared: got %0d want 315", mush_y); end
    endtask

    task automatic test_fall_off();
        bit saw_coll = 0;
        do_reset();
        mario_far();
        ground_below = 1'b1;
        spawn_and_rise(50, 472);
        ground_below = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0);
            if (collision) saw_coll = 1;
            checks++; if (mush_y !== 10'(m_y) || mush_active !== model_in_play()) begin
                errors++; $display("FAIL falloff_step%0d: got y=%0d act=%b want %0d %b", i, mush_y, mush_active, m_y, model_in_play());
            end
        end
        checks++; if (mush_active !== 1'b0 || mush_y !== 10'd482) begin
            errors++; $display("FAIL falloff_done: got act=%b y=%0d want 0 482", mush_active, mush_y);
        end
        checks++; if (saw_coll !== 1'b0) begin errors++; $display("FAIL falloff_collision: got %b want 0", saw_coll); end
    endtask

    task automatic test_collect();
        int pulses = 0;
        do_reset();
        mario_far();
        ground_below = 1'b1;
        spawn_and_rise(200, 316);
        mario_x = 10'd185; mario_y = 10'd300; mario_h = 6'd16;
        #1;
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL collect_early: got %b want 0", collision); end
        cyc(1'b1, 1'b0);
        checks++; if (collision !== 1'b1 || mush_active !== 1'b0 || mush_x !== 10'd200) begin
            errors++; $display("FAIL collect_pulse: got coll=%b act=%b x=%0d want 1 0 200", collision, mush_active, mush_x);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(i[0], 1'b0);
            if (collision) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL collect_repeat: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_reset_mid_fall();
        do_reset();
        mario_far();
        ground_below = 1'b1;
        spawn_and_rise(300, 216);
        ground_below = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        #1;
        Reset_n = 1'b0;
        #1;
        checks++; if (mush_x !== 10'd0 || mush_y !== 10'd0 || mush_active !== 1'b0 || collision !== 1'b0) begin
            errors++; $display("FAIL midfall_reset: got x=%0d y=%0d act=%b coll=%b want 0 0 0 0", mush_x, mush_y, mush_active, collision);
        end
        model_reset();
        #1;
        Reset_n = 1'b1;
        ground_below = 1'b1;
        spawn_x = 10'd40; spawn_y = 10'd100;
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        checks++; if (mush_active !== 1'b1 || mush_x !== 10'd40 || mush_y !== 10'd99) begin
            errors++; $display("FAIL midfall_respawn: got act=%b x=%0d y=%0d want 1 40 99", mush_active, mush_x, mush_y);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit tk, sp;
            tk = ($urandom_range(0, 2) == 0);
            sp = ($urandom_range(0, 24) == 0);
            ground_below = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 1) == 0) spawn_x = 10'($urandom_range(0, 8));
            else spawn_x = 10'($urandom_range(0, 630));
            spawn_y = 10'($urandom_range(0, 470));
            if ($urandom_range(0, 29) == 0) begin
                int nx = m_x + int'($urandom_range(0, 40)) - 20;
                int ny = m_y + int'($urandom_range(0, 50)) - 25;
                mario_x = 10'((nx < 0) ? 0 : nx);
                mario_y = 10'((ny < 0) ? 0 : ny);
                mario_h = ($urandom_range(0, 1) == 0) ? 6'd16 : 6'd32;
            end else if ($urandom_range(0, 9) == 0) begin
                mario_far();
            end
            cyc(tk, sp);
            checks++; if (mush_x !== 10'(m_x)) begin errors++; $display("FAIL rand_x cyc%0d: got %0d want %0d", i, mush_x, m_x); end
            checks++; if (mush_y !== 10'(m_y)) begin errors++; $display("FAIL rand_y cyc%0d: got %0d want %0d", i, mush_y, m_y); end
            checks++; if (mush_active !== model_in_play()) begin errors++; $display("FAIL rand_active cyc%0d: got %b want %b", i, mush_active, model_in_play()); end
            checks++; if (collision !== 1'(m_coll)) begin errors++; $display("FAIL rand_collision cyc%0d: got %b want %0d", i, collision, m_coll); end
        end
    endtask

    initial begin
        model_reset();
        mario_far();
        test_reset();
        test_emerge();
        test_right_wall();
        test_fall();
        test_fall_off();
        test_collect();
        test_reset_mid_fall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mushroom_motion.md
# mushroom_motion

Moves a power-up mushroom after it is released from a struck block: rises out of the block, walks, falls under gravity and detects overlap with Mario. Sits directly upstream of the mushroom visibility FSM: its `collision` pulse is that FSM's `collision` input. It also drives the mushroom sprite position to the colour mapper. All motion advances once per frame tick; overlap detection runs every clock.

## Interface
Parameters:
- SIZE, 16: mushroom width and height in pixels; also the emerge distance.
- WALK_SPEED, 1: horizontal pixels per frame.
- GRAVITY, 1: vertical speed increment per frame while falling.
- MAX_FALL, 4: vertical speed cap, in pixels per frame.
- SCREEN_W, 640 / SCREEN_H, 480: playfield bounds.
- MARIO_W, 16: Mario hitbox width.

Ports:
- Clk, input, 1: single system clock.
- Reset_n, input, 1: asynchronous, active-low reset.
- frame_tick, input, 1: one-Clk pulse per video frame.
- spawn, input, 1: one-Clk pulse when a mushroom block is struck.
- spawn_x, spawn_y, input, 10 each: top-left corner of the struck block.
- mario_x, mario_y, input, 10 each: Mario hitbox top-left corner.
- mario_h, input, 6: Mario hitbox height (16 small, 32 big).
- ground_below, input, 1: level lookup; 1 means a solid tile is directly under the mushroom's current position.
- mush_x, mush_y, output, 10 each: sprite top-left corner.
- mush_active, output, 1: mushroom is in play (EMERGE, WALK or FALL).
- collision, output, 1: one-Clk pulse when Mario touches the mushroom.

## Operation
- States: IDLE, EMERGE, WALK, FALL, DONE.
- Reset values: state IDLE, mush_x=0, mush_y=0, dir=right, vy=0, emerge_cnt=0, mush_active=0, collision=0.
- IDLE or DONE + spawn: mush_x=spawn_x, mush_y=spawn_y, emerge_cnt=SIZE, dir=right, vy=0, go to EMERGE.
- spawn while in EMERGE, WALK or FALL: ignored.
- EMERGE, on each tick:
  - mush_y decrements by 1 (saturates at 0) and emerge_cnt decrements.
  - When emerge_cnt reaches 0, go to WALK.
- WALK, on each tick:
  - If ground_below=0, go to FALL; x does not move on that tick.
  - Otherwise x moves by ±WALK_SPEED.
  - Right wall: if x+WALK_SPEED+SIZE ≥ SCREEN_W, clamp x to SCREEN_W−SIZE and set dir=left.
  - Left wall: if x < WALK_SPEED, clamp x to 0 and set dir=right.
- FALL, on each tick:
  - If ground_below=1, set vy=0 and go to WALK; y does not change.
  - Otherwise vy=min(vy+GRAVITY, MAX_FALL) and y += new vy. x is frozen.
  - If the new y ≥ SCREEN_H, go to DONE with no collision (mushroom lost).
- Overlap is evaluated every Clk cycle in EMERGE, WALK and FALL as an AABB test:
  - mario_x < mush_x+SIZE, and mush_x < mario_x+MARIO_W,
  - mario_y < mush_y+SIZE, and mush_y < mario_y+mario_h.
  - All compares use 11-bit zero-extended operands, so no wrap.
- When overlap is true: collision=1 for one cycle and go to DONE.
- DONE: position holds, mush_active=0, collision=0.

## Timing
- Overlap is computed combinationally from registered position and live Mario inputs.
- collision and the move to DONE are registered on the same edge: one cycle of latency from overlap.
- collision is high for exactly one cycle, at most once per spawn.
- Overlap coinciding with frame_tick: collision wins and position does not update.
- spawn coinciding with frame_tick in IDLE/DONE: spawn is taken; the first emerge step happens on the next tick.
- ground_below is sampled on the tick cycle only.
- Reset_n low at any time forces reset values immediately. Any in-flight mushroom is discarded and no collision is emitted.
- mush_active is registered state decode and is high the cycle after spawn is accepted.

## Structure
- Package mushroom_pkg holds:
  - enum mush_state_t {IDLE, EMERGE, WALK, FALL, DONE};
  - localparam defaults for SIZE, SCREEN_W, SCREEN_H;
  - enum dir_t {LEFT, RIGHT}.
- Sub-module aabb_overlap: combinational, takes two boxes and returns overlap. It will be reused for goombas and coins.
- Top level holds the FSM, position/velocity registers and emerge counter.

## Test plan
- Emerge: spawn at (100,200), 16 ticks, Mario far away, ground_below=1. mush_y steps 199…184, then WALK. The next tick gives mush_x=101.
- Right wall: WALK at x=623, dir right, tick. x clamps to 624 and dir=left; the next tick gives x=623.
- Fall: ground_below=0 for 5 ticks from y=300. vy goes 1,2,3,4,4 and y reaches 314. ground_below=1 then returns to WALK with vy=0.
- Fall off screen: fall from y=470 with vy=4. DONE once y ≥ 480, collision never asserted, mush_active=0.
- Collection: WALK at (200,300), Mario moved to (185,300), mario_h=16. collision is a single pulse one cycle later, then DONE. Holding Mario in place produces no second pulse.
- Reset mid-FALL: assert Reset_n=0 between edges. Outputs go to zero immediately. A spawn after release restarts normally.
